// File: rtl/ines_loader.sv
// ----------------------------------------------------------------------------
// ines_loader
//
// Streams an iNES cartridge image from the UART receive path into the
// cartridge PRG/CHR ROM programming ports. The 16-byte header is validated,
// an optional 512-byte trainer is skipped, and PRG then CHR payload bytes are
// written at ascending addresses starting at 0. A one-byte status ('S' ok,
// 'F' bad header, 'T' stream timeout) is returned on the transmit path.
//
// Optional feature macro: INES_LOADER_CHECKSUM_EN
//   When defined, an 8-bit running sum of all PRG and CHR payload bytes is
//   sent as a second status byte after a successful 'S'.
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   abort                 synchronous cancel back to IDLE (no status sent)
//   rx_data/valid/ready   input byte stream (accept on rx_valid && rx_ready)
//   tx_data/valid/ready   status byte stream
//   prg_we/addr/data      PRG ROM programming port (registered strobe)
//   chr_we/addr/data      CHR ROM programming port (registered strobe)
//   busy                  high whenever the loader is not IDLE
//   done, error           sticky result flags
//   prg_banks, chr_banks, mapper, mirror   captured header fields
// ----------------------------------------------------------------------------
module ines_loader #(
  parameter int unsigned PRG_AW         = 15,
  parameter int unsigned CHR_AW         = 13,
  parameter int unsigned MAX_PRG_BANKS  = 2,
  parameter int unsigned MAX_CHR_BANKS  = 1,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              abort,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              prg_we,
  output logic [PRG_AW-1:0] prg_addr,
  output logic [7:0]        prg_data,
  output logic              chr_we,
  output logic [CHR_AW-1:0] chr_addr,
  output logic [7:0]        chr_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [7:0]        prg_banks,
  output logic [7:0]        chr_banks,
  output logic [7:0]        mapper,
  output logic              mirror
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_TRAINER,
    S_PRG,
    S_CHR,
    S_REPORT
`ifdef INES_LOADER_CHECKSUM_EN
    , S_SUM
`endif
  } state_t;

  localparam logic [7:0]  ST_OK      = 8'h53;  // 'S'
  localparam logic [7:0]  ST_FAIL    = 8'h46;  // 'F'
  localparam logic [7:0]  ST_TIMEOUT = 8'h54;  // 'T'
  localparam logic [31:0] TO_LAST    = 32'(TIMEOUT_CYCLES - 1);

  state_t              state_q, state_d;
  logic [23:0]         idx_q, idx_d;        // header index / byte counter
  logic [31:0]         tmo_q, tmo_d;
  logic [7:0]          status_q, status_d;
  logic                trainer_q, trainer_d;
  logic [7:0]          prg_banks_q, prg_banks_d;
  logic [7:0]          chr_banks_q, chr_banks_d;
  logic [7:0]          mapper_q, mapper_d;
  logic                mirror_q, mirror_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                prg_we_q, prg_we_d;
  logic [PRG_AW-1:0]   prg_addr_q, prg_addr_d;
  logic [7:0]          prg_data_q, prg_data_d;
  logic                chr_we_q, chr_we_d;
  logic [CHR_AW-1:0]   chr_addr_q, chr_addr_d;
  logic [7:0]          chr_data_q, chr_data_d;
`ifdef INES_LOADER_CHECKSUM_EN
  logic [7:0]          sum_q, sum_d;
`endif

  logic        accept;
  logic        loading;
  logic        tmo_hit;
  logic [23:0] prg_last;
  logic [23:0] chr_last;

  // abort masks rx_ready, so an aborted byte is never accepted.
  assign rx_ready = (state_q inside {S_IDLE, S_HEADER, S_TRAINER, S_PRG, S_CHR}) && !abort;
  assign accept   = rx_valid && rx_ready;
  assign loading  = state_q inside {S_HEADER, S_TRAINER, S_PRG, S_CHR};
  assign tmo_hit  = (tmo_q == TO_LAST);

  // Index of the final payload byte: banks*16 KiB - 1 and banks*8 KiB - 1.
  assign prg_last = {2'b00, prg_banks_q, 14'd0} - 24'd1;
  assign chr_last = {3'b000, chr_banks_q, 13'd0} - 24'd1;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tmo_d       = 32'd0;
    status_d    = status_q;
    trainer_d   = trainer_q;
    prg_banks_d = prg_banks_q;
    chr_banks_d = chr_banks_q;
    mapper_d    = mapper_q;
    mirror_d    = mirror_q;
    done_d      = done_q;
    error_d     = error_q;
    prg_we_d    = 1'b0;
    prg_addr_d  = prg_addr_q;
    prg_data_d  = prg_data_q;
    chr_we_d    = 1'b0;
    chr_addr_d  = chr_addr_q;
    chr_data_d  = chr_data_q;
`ifdef INES_LOADER_CHECKSUM_EN
    sum_d       = sum_q;
`endif

    // Idle-cycle counter only runs while a load is in progress.
    if (loading && !accept) begin
      tmo_d = tmo_q + 32'd1;
    end

    if (abort) begin
      state_d = S_IDLE;
    end else if (loading && !accept && tmo_hit) begin
      state_d  = S_REPORT;
      status_d = ST_TIMEOUT;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            done_d  = 1'b0;
            error_d = 1'b0;
            idx_d   = 24'd1;
`ifdef INES_LOADER_CHECKSUM_EN
            sum_d   = 8'h00;
`endif
            if (rx_data != 8'h4E) begin
              state_d  = S_REPORT;
              status_d = ST_FAIL;
            end else begin
              state_d = S_HEADER;
            end
          end
        end

        S_HEADER: begin
          if (accept) begin
            idx_d = idx_q + 24'd1;
            case (idx_q[3:0])
              4'd1: if (rx_data != 8'h45) begin state_d = S_REPORT; status_d = ST_FAIL; end
              4'd2: if (rx_data != 8'h53) begin state_d = S_REPORT; status_d = ST_FAIL; end
              4'd3: if (rx_data != 8'h1A) begin state_d = S_REPORT; status_d = ST_FAIL; end
              4'd4: begin
                prg_banks_d = rx_data;
                if (rx_data == 8'd0 || 32'(rx_data) > MAX_PRG_BANKS) begin
                  state_d  = S_REPORT;
                  status_d = ST_FAIL;
                end
              end
              4'd5: begin
                chr_banks_d = rx_data;
                if (32'(rx_data) > MAX_CHR_BANKS) begin
                  state_d  = S_REPORT;
                  status_d = ST_FAIL;
                end
              end
              4'd6: begin
                mirror_d      = rx_data[0];
                trainer_d     = rx_data[2];
                mapper_d[3:0] = rx_data[7:4];
              end
              4'd7: mapper_d[7:4] = rx_data[7:4];
              4'd15: begin
                idx_d   = 24'd0;
                state_d = trainer_q ? S_TRAINER : S_PRG;
              end
              default: ;
            endcase
          end
        end

        S_TRAINER: begin
          if (accept) begin
            if (idx_q == 24'd511) begin
              idx_d   = 24'd0;
              state_d = S_PRG;
            end else begin
              idx_d = idx_q + 24'd1;
            end
          end
        end

        S_PRG: begin
          if (accept) begin
            prg_we_d   = 1'b1;
            prg_addr_d = idx_q[PRG_AW-1:0];
            prg_data_d = rx_data;
`ifdef INES_LOADER_CHECKSUM_EN
            sum_d      = sum_q + rx_data;
`endif
            if (idx_q == prg_last) begin
              idx_d = 24'd0;
              if (chr_banks_q != 8'd0) begin
                state_d = S_CHR;
              end else begin
                state_d  = S_REPORT;
                status_d = ST_OK;
              end
            end else begin
              idx_d = idx_q + 24'd1;
            end
          end
        end

        S_CHR: begin
          if (accept) begin
            chr_we_d   = 1'b1;
            chr_addr_d = idx_q[CHR_AW-1:0];
            chr_data_d = rx_data;
`ifdef INES_LOADER_CHECKSUM_EN
            sum_d      = sum_q + rx_data;
`endif
            if (idx_q == chr_last) begin
              idx_d    = 24'd0;
              state_d  = S_REPORT;
              status_d = ST_OK;
            end else begin
              idx_d = idx_q + 24'd1;
            end
          end
        end

        S_REPORT: begin
          if (tx_ready) begin
            state_d = S_IDLE;
            if (status_q == ST_OK) begin
`ifdef INES_LOADER_CHECKSUM_EN
              state_d = S_SUM;
`else
              done_d  = 1'b1;
`endif
            end else begin
              error_d = 1'b1;
            end
          end
        end

`ifdef INES_LOADER_CHECKSUM_EN
        S_SUM: begin
          if (tx_ready) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
`endif

        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= 24'd0;
      tmo_q       <= 32'd0;
      status_q    <= 8'h00;
      trainer_q   <= 1'b0;
      prg_banks_q <= 8'h00;
      chr_banks_q <= 8'h00;
      mapper_q    <= 8'h00;
      mirror_q    <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      prg_we_q    <= 1'b0;
      prg_addr_q  <= '0;
      prg_data_q  <= 8'h00;
      chr_we_q    <= 1'b0;
      chr_addr_q  <= '0;
      chr_data_q  <= 8'h00;
`ifdef INES_LOADER_CHECKSUM_EN
      sum_q       <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tmo_q       <= tmo_d;
      status_q    <= status_d;
      trainer_q   <= trainer_d;
      prg_banks_q <= prg_banks_d;
      chr_banks_q <= chr_banks_d;
      mapper_q    <= mapper_d;
      mirror_q    <= mirror_d;
      done_q      <= done_d;
      error_q     <= error_d;
      prg_we_q    <= prg_we_d;
      prg_addr_q  <= prg_addr_d;
      prg_data_q  <= prg_data_d;
      chr_we_q    <= chr_we_d;
      chr_addr_q  <= chr_addr_d;
      chr_data_q  <= chr_data_d;
`ifdef INES_LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  // Status byte is presented for as long as the REPORT/SUM state lasts.
  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    if (state_q == S_REPORT) begin
      tx_valid = 1'b1;
      tx_data  = status_q;
    end
`ifdef INES_LOADER_CHECKSUM_EN
    if (state_q == S_SUM) begin
      tx_valid = 1'b1;
      tx_data  = sum_q;
    end
`endif
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign error     = error_q;
  assign prg_we    = prg_we_q;
  assign prg_addr  = prg_addr_q;
  assign prg_data  = prg_data_q;
  assign chr_we    = chr_we_q;
  assign chr_addr  = chr_addr_q;
  assign chr_data  = chr_data_q;
  assign prg_banks = prg_banks_q;
  assign chr_banks = chr_banks_q;
  assign mapper    = mapper_q;
  assign mirror    = mirror_q;

endmodule

// File: tb/tb_ines_loader.sv
// ----------------------------------------------------------------------------
// tb_ines_loader
//
// Directed sequence of iNES image transfers with randomized header padding,
// payload and inter-byte gaps. Expected ROM writes are derived from the image
// layout (header size, trainer flag, bank counts) and checked by a monitor,
// including their address, data and one-cycle latency. Status bytes are
// collected from the transmit handshake.
// ----------------------------------------------------------------------------
module tb_ines_loader;

  localparam int TMO = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        prg_we;
  logic [14:0] prg_addr;
  logic [7:0]  prg_data;
  logic        chr_we;
  logic [12:0] chr_addr;
  logic [7:0]  chr_data;
  logic        busy, done, error, mirror;
  logic [7:0]  prg_banks, chr_banks, mapper;

  ines_loader #(
    .PRG_AW(15), .CHR_AW(13), .MAX_PRG_BANKS(2), .MAX_CHR_BANKS(1),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .abort(abort),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .prg_we(prg_we), .prg_addr(prg_addr), .prg_data(prg_data),
    .chr_we(chr_we), .chr_addr(chr_addr), .chr_data(chr_data),
    .busy(busy), .done(done), .error(error),
    .prg_banks(prg_banks), .chr_banks(chr_banks), .mapper(mapper), .mirror(mirror)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_prg_wr = 0;
  int n_chr_wr = 0;
  int model_sum = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int addr;
    int data;
    int due;
  } wr_t;

  wr_t        prg_exp[$];
  wr_t        chr_exp[$];
  wr_t        e_mon;
  logic [7:0] tx_q[$];
  logic [7:0] img[$];
  logic       hold_q = 1'b0;
  logic [7:0] hold_data = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (prg_we === 1'b1) begin
      n_prg_wr++;
      if (prg_exp.size() == 0) begin
        check("prg_unexpected_write", 32'(prg_addr), 32'hFFFF_FFFF);
      end else begin
        e_mon = prg_exp.pop_front();
        check("prg_addr", 32'(prg_addr), e_mon.addr);
        check("prg_data", 32'(prg_data), e_mon.data);
        check("prg_latency", cyc, e_mon.due);
      end
    end else if (prg_exp.size() != 0 && prg_exp[0].due <= cyc) begin
      check("prg_missing_write", 32'(prg_we), 32'd1);
      void'(prg_exp.pop_front());
    end
    if (chr_we === 1'b1) begin
      n_chr_wr++;
      if (chr_exp.size() == 0) begin
        check("chr_unexpected_write", 32'(chr_addr), 32'hFFFF_FFFF);
      end else begin
        e_mon = chr_exp.pop_front();
        check("chr_addr", 32'(chr_addr), e_mon.addr);
        check("chr_data", 32'(chr_data), e_mon.data);
        check("chr_latency", cyc, e_mon.due);
      end
    end else if (chr_exp.size() != 0 && chr_exp[0].due <= cyc) begin
      check("chr_missing_write", 32'(chr_we), 32'd1);
      void'(chr_exp.pop_front());
    end
    if (hold_q) begin
      check("tx_valid_hold", 32'(tx_valid), 32'd1);
      check("tx_data_hold", 32'(tx_data), 32'(hold_data));
    end
    hold_q    <= tx_valid && !tx_ready && !abort && rst_n;
    hold_data <= tx_data;
    if (tx_valid && tx_ready && !abort && rst_n) tx_q.push_back(tx_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, output bit acc, output int c);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    acc = rx_ready;
    c   = cyc;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic build_header(input int prg, input int chr, input int f6, input int f7);
    img.delete();
    img.push_back(8'h4E);
    img.push_back(8'h45);
    img.push_back(8'h53);
    img.push_back(8'h1A);
    img.push_back(8'(prg));
    img.push_back(8'(chr));
    img.push_back(8'(f6));
    img.push_back(8'(f7));
    for (int i = 0; i < 8; i++) img.push_back(8'($urandom_range(255)));
  endtask

  // Sends img[0..upto-1]; expected writes follow from the image layout.
  task automatic run_image(input int upto, input bit gaps, output int last_c);
    int prg_off, prg_len, chr_off, chr_len, c, n_acc;
    bit acc;
    logic [7:0] f6;
    f6      = img[6];
    prg_off = 16 + (f6[2] ? 512 : 0);
    prg_len = int'(img[4]) * 16384;
    chr_off = prg_off + prg_len;
    chr_len = int'(img[5]) * 8192;
    n_acc   = 0;
    last_c  = 0;
    model_sum = 0;
    for (int k = 0; k < upto; k++) begin
      if (gaps && $urandom_range(15) == 0) tick();
      send_byte(img[k], acc, c);
      if (!acc) break;
      n_acc++;
      last_c = c;
      if (k >= prg_off && k < chr_off) begin
        prg_exp.push_back('{addr: k - prg_off, data: int'(img[k]), due: c + 1});
        model_sum += int'(img[k]);
      end else if (k >= chr_off && k < chr_off + chr_len) begin
        chr_exp.push_back('{addr: k - chr_off, data: int'(img[k]), due: c + 1});
        model_sum += int'(img[k]);
      end
    end
    check("stream_accepted", 32'(n_acc), 32'(upto));
  endtask

  task automatic get_tx(input string tag, input logic [7:0] exp);
    bit ok;
    logic [7:0] b;
    ok = 1'b0;
    b  = 8'h00;
    tx_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (tx_q.size() > 0) begin
        b  = tx_q.pop_front();
        ok = 1'b1;
        break;
      end
      tick();
    end
    tx_ready = 1'b0;
    check({tag, "_seen"}, 32'(ok), 32'd1);
    check(tag, 32'(b), 32'(exp));
    $display("tx transfer %s: byte %h", tag, b);
  endtask

  task automatic check_reset_state(input string p);
    check({p, "_rx_ready"}, 32'(rx_ready), 32'd1);
    check({p, "_tx_valid"}, 32'(tx_valid), 32'd0);
    check({p, "_tx_data"}, 32'(tx_data), 32'd0);
    check({p, "_busy"}, 32'(busy), 32'd0);
    check({p, "_we"}, {30'd0, prg_we, chr_we}, 32'd0);
    check({p, "_flags"}, {30'd0, done, error}, 32'd0);
    check({p, "_fields"}, {prg_banks, chr_banks, mapper, 7'd0, mirror}, 32'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time exceeded at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c, last_c, wr0, cw0, seen;
    bit acc;

    // ---- reset values ----
    #12;
    check_reset_state("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // ---- full load: 1 PRG bank + 1 CHR bank, payload = index mod 256 ----
    build_header(1, 1, 8'h00, 8'h00);
    for (int i = 0; i < 16384 + 8192; i++) img.push_back(8'(i & 255));
    wr0 = n_prg_wr;
    cw0 = n_chr_wr;
    run_image(img.size(), 1'b1, last_c);
    repeat (20) tick();
    @(negedge clk);
    check("t1_tx_valid", 32'(tx_valid), 32'd1);
    check("t1_tx_data", 32'(tx_data), 32'h53);
    check("t1_done_pending", 32'(done), 32'd0);
    check("t1_rx_ready_report", 32'(rx_ready), 32'd0);
    tick();
    get_tx("t1_status", 8'h53);
`ifdef INES_LOADER_CHECKSUM_EN
    check("t1_model_sum_zero", 32'(model_sum & 255), 32'd0);
    get_tx("t1_sum", 8'(model_sum & 255));
`endif
    tx_ready = 1'b1;
    repeat (3) tick();
    tx_ready = 1'b0;
    check("t1_single_transfer", 32'(tx_q.size()), 32'd0);
    check("t1_done", {30'd0, done, error}, 32'd2);
    check("t1_prg_count", 32'(n_prg_wr - wr0), 32'd16384);
    check("t1_chr_count", 32'(n_chr_wr - cw0), 32'd8192);
    check("t1_queues_empty", 32'(prg_exp.size() + chr_exp.size()), 32'd0);
    check("t1_fields", {prg_banks, chr_banks, mapper, 7'd0, mirror}, 32'h0101_0000);
    $display("transaction full load: prg %0d chr %0d writes", n_prg_wr - wr0, n_chr_wr - cw0);

    // ---- bad first byte ----
    send_byte(8'h4D, acc, c);
    check("t2_accept", 32'(acc), 32'd1);
    check("t2_flags_cleared", {30'd0, done, error}, 32'd0);
    @(negedge clk);
    check("t2_tx_valid", 32'(tx_valid), 32'd1);
    check("t2_tx_data", 32'(tx_data), 32'h46);
    check("t2_rx_ready", 32'(rx_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      check("t2_rx_ready_hold", 32'(rx_ready), 32'd0);
    end
    tick();
    get_tx("t2_status", 8'h46);
    check("t2_flags", {30'd0, done, error}, 32'd1);
    check("t2_idle", {30'd0, busy, rx_ready}, 32'd1);
    $display("transaction bad magic: error %0b", error);

    // ---- too many PRG banks ----
    build_header(3, 1, 8'h00, 8'h00);
    run_image(5, 1'b0, last_c);
    @(negedge clk);
    check("t3_tx_data", {23'd0, tx_valid, tx_data}, 32'h146);
    check("t3_prg_banks", 32'(prg_banks), 32'd3);
    tick();
    get_tx("t3_status", 8'h46);
    check("t3_error", 32'(error), 32'd1);
    $display("transaction bad prg banks: error %0b", error);

    // ---- trainer, mapper 1, CHR RAM ----
    build_header(1, 0, 8'h14, 8'h00);
    for (int i = 0; i < 512 + 16384; i++) img.push_back(8'($urandom_range(255)));
    wr0 = n_prg_wr;
    cw0 = n_chr_wr;
    run_image(img.size(), 1'b0, last_c);
    tick();
    check("t4_fields", {prg_banks, chr_banks, mapper, 7'd0, mirror}, 32'h0100_0100);
    get_tx("t4_status", 8'h53);
`ifdef INES_LOADER_CHECKSUM_EN
    get_tx("t4_sum", 8'(model_sum & 255));
`endif
    tick();
    check("t4_done", {30'd0, done, error}, 32'd2);
    check("t4_prg_count", 32'(n_prg_wr - wr0), 32'd16384);
    check("t4_chr_count", 32'(n_chr_wr - cw0), 32'd0);
    $display("transaction trainer load: prg %0d writes, mapper %h", n_prg_wr - wr0, mapper);

    // ---- timeout after 100 PRG bytes ----
    build_header(1, 1, 8'h00, 8'h00);
    for (int i = 0; i < 100; i++) img.push_back(8'($urandom_range(255)));
    run_image(img.size(), 1'b0, last_c);
    seen = 0;
    for (int i = 0; i < TMO + 200; i++) begin
      @(negedge clk);
      if (tx_valid === 1'b1) begin
        seen = cyc;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("t5_timeout_latency", 32'(seen), 32'(last_c + 1 + TMO));
    check("t5_tx_data", 32'(tx_data), 32'h54);
    tick();
    get_tx("t5_status", 8'h54);
    check("t5_flags", {30'd0, done, error}, 32'd1);
    $display("transaction timeout: status after %0d cycles", seen - last_c - 1);

    // ---- abort mid-PRG on the same cycle as rx_valid ----
    build_header(1, 1, 8'h00, 8'h00);
    for (int i = 0; i < 50; i++) img.push_back(8'($urandom_range(255)));
    run_image(img.size(), 1'b0, last_c);
    abort    = 1'b1;
    rx_data  = 8'hA5;
    rx_valid = 1'b1;
    @(negedge clk);
    check("t6_rx_ready_abort", 32'(rx_ready), 32'd0);
    tick();
    abort    = 1'b0;
    rx_valid = 1'b0;
    @(negedge clk);
    check("t6_idle", {29'd0, busy, tx_valid, rx_ready}, 32'd1);
    check("t6_flags", {30'd0, done, error}, 32'd0);
    tick();
    tx_ready = 1'b1;
    repeat (3) tick();
    tx_ready = 1'b0;
    check("t6_no_tx", 32'(tx_q.size()), 32'd0);
    $display("transaction abort: busy %0b", busy);

    // ---- asynchronous reset mid-CHR ----
    build_header(1, 1, 8'h00, 8'h00);
    for (int i = 0; i < 16384 + 10; i++) img.push_back(8'($urandom_range(255)));
    run_image(img.size(), 1'b0, last_c);
    check("t7_pre_reset", {29'd0, busy, chr_we, prg_we}, 32'd6);
    #1;
    rst_n = 1'b0;
    #1;
    chr_exp.delete();
    check_reset_state("t7_reset");
    tick();
    rst_n = 1'b1;
    tick();
    check("t7_after_release", {30'd0, busy, rx_ready}, 32'd1);
    $display("transaction reset mid-CHR: busy %0b", busy);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ines_loader.md
# ines_loader

Parametrised iNES image loader that succeeds the top-level verify-then-load controller. It consumes a byte stream from the UART receive path, validates the 16-byte iNES header, and skips the optional 512-byte trainer. It then streams PRG and CHR payloads into the cartridge ROM programming ports with generated addresses and reports a status byte on the UART transmit path. It sits between the UART core and `rom_master`, and holds the NES in reset through `busy` while loading.

## Interface
Parameters:
- `PRG_AW`, 15: PRG programming address width; MAX_PRG_BANKS*16384 must be ≤ 2^PRG_AW.
- `CHR_AW`, 13: CHR programming address width; MAX_CHR_BANKS*8192 must be ≤ 2^CHR_AW.
- `MAX_PRG_BANKS`, 2: largest accepted header byte 4 (16 KiB units).
- `MAX_CHR_BANKS`, 1: largest accepted header byte 5 (8 KiB units).
- `TIMEOUT_CYCLES`, 50_000_000: idle cycles mid-load before abort; 32-bit counter.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `abort` in 1: synchronous cancel, returns to IDLE silently.
- `rx_data` in 8, `rx_valid` in 1, `rx_ready` out 1: input byte stream.
- `tx_data` out 8, `tx_valid` out 1, `tx_ready` in 1: status byte stream.
- `prg_we` out 1, `prg_addr` out PRG_AW, `prg_data` out 8: PRG ROM write port.
- `chr_we` out 1, `chr_addr` out CHR_AW, `chr_data` out 8: CHR ROM write port.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1, `error` out 1: sticky result flags.
- `prg_banks` out 8, `chr_banks` out 8, `mapper` out 8, `mirror` out 1: captured header fields.

## Operation
- States: IDLE, HEADER, TRAINER, PRG, CHR, REPORT, plus SUM when the checksum feature is compiled in.
- A byte is accepted on any edge with `rx_valid && rx_ready`.
- `rx_ready` = (state ∈ {IDLE, HEADER, TRAINER, PRG, CHR}) && !`abort`.
- IDLE: an accepted byte is header byte 0. It clears `done`/`error` and enters HEADER with index 1.
- Header bytes 0–3 must equal 0x4E, 0x45, 0x53, 0x1A. A mismatch goes to REPORT with 'F' (0x46) on that byte.
- Byte 4 → `prg_banks`. A value of 0 or greater than MAX_PRG_BANKS gives 'F'.
- Byte 5 → `chr_banks`. A value greater than MAX_CHR_BANKS gives 'F'; 0 is legal and means CHR RAM.
- Byte 6: bit0 → `mirror`, bit2 → trainer flag, bits7:4 → `mapper[3:0]`.
- Byte 7: bits7:4 → `mapper[7:4]`. Bytes 8–15 are ignored.
- After byte 15, the next state is TRAINER if the trainer flag is set, otherwise PRG.
- TRAINER discards exactly 512 bytes, then enters PRG.
- PRG writes `prg_banks`*16384 bytes at addresses 0 upward.
- Then CHR, if `chr_banks` ≠ 0, writes `chr_banks`*8192 bytes at addresses 0 upward. Otherwise go straight to REPORT with 'S' (0x53).
- Byte counters are 24 bits wide. Addresses never wrap, because the parameter constraint forbids it.
- REPORT: hold `tx_valid` high with `tx_data` until the cycle `tx_ready` is also high. Then:
  - 'S' sets `done`.
  - 'F' or 'T' sets `error`.
  - The next state is IDLE, or SUM after 'S' when the checksum feature is enabled.
- Timeout: the counter clears on every accepted byte and in IDLE/REPORT/SUM. When it reaches TIMEOUT_CYCLES in HEADER–CHR, go to REPORT with 'T' (0x54).
- Simultaneous events:
  - `abort` beats an incoming byte (the byte is not accepted) and beats a timeout.
  - An accepted byte beats a timeout on the same cycle.
- `abort` in any state goes to IDLE. It leaves `done`/`error` unchanged and cancels any pending tx.
- `rst_n` asserted mid-load returns the block to reset state immediately. ROM contents already written are left as they are.

## Timing
- Reset values: state IDLE, `rx_ready`=1, every other output 0, header fields 0.
- Write latency: a byte accepted at edge t drives `*_we`=1 with `*_addr`/`*_data` for the single cycle after t. The write strobes are registered.
- One byte per cycle is sustained. Back-to-back bytes give back-to-back write pulses at consecutive addresses.
- The last PRG byte's write pulse coincides with the first cycle in CHR. CHR is ready on that cycle.
- `tx_valid` rises on the cycle after entering REPORT. The REPORT→IDLE transition occurs on the handshake edge.
- `done`/`error` update on the handshake edge.

## Configuration
- `INES_LOADER_CHECKSUM_EN` defined:
  - An 8-bit running sum (mod 256) is kept over PRG and CHR payload bytes only.
  - After a successful 'S' handshake, SUM sends the sum as a second tx byte, with the same tx handshake, then goes to IDLE.
  - `done` sets after the second handshake.
- Undefined: no SUM state, no accumulator, and 'S' is the final byte.

## Test plan
- Send header 4E 45 53 1A 01 01 00…, then 16384+8192 payload bytes with value = index mod 256:
  - `prg_we` pulses 16384 times at addresses 0–0x3FFF.
  - `chr_we` pulses 8192 times at addresses 0–0x1FFF.
  - tx sends 0x53, then (checksum on) the sum 0x00; `done`=1.
- Send first byte 0x4D → tx 0x46 on the next cycle, `error`=1, no write pulses, and `rx_ready`=0 until the tx handshake.
- Send header with byte 4 = 03 → 'F' on that byte. Header with byte 6 = 0x14 → 512 bytes skipped, `mapper`=0x01, `prg_we` starts on payload byte 513.
- Stop the stream after 100 PRG bytes, with TIMEOUT_CYCLES=1000 → tx 0x54 exactly 1000 cycles after the last accepted byte.
- Assert `abort` mid-PRG on the same cycle as `rx_valid` → byte not accepted, state IDLE next cycle, no tx. Deassert `rst_n` mid-CHR → all outputs at reset values asynchronously.
- Hold `tx_ready`=0 for 20 cycles in REPORT → `tx_valid`/`tx_data` stable throughout, and single transfer on release.
